mm_param: RTL and testbench
===========================

# mm_param

Parametrised matrix-multiply accelerator, the successor to the fixed 4x4 `mm` block. It sits behind the same AXI-Lite control port and AXI-Stream data ports. Two N×N signed matrices stream in, and their product streams out, with N set at run time up to `MAX_N`. It adds a run-time dimension register, output backpressure hold, and a sticky framing-error flag.

## Interface
Parameters:
- `pADDR_WIDTH`, 12: AXI-Lite address width.
- `pDATA_WIDTH`, 32: stream and register data width.
- `MAX_N`, 8: largest supported dimension. Storage is 2·MAX_N² words.

Ports:
- `axis_clk`  in  1: single clock.
- `axis_rst_n`  in  1: reset, asynchronous, active-low.
- `awvalid`/`awready`, `wvalid`/`wready`  in/out  1 each: AXI-Lite write handshakes.
- `awaddr`  in  pADDR_WIDTH; `wdata`  in  pDATA_WIDTH: write address and data.
- `arvalid`/`arready`, `rvalid`/`rready`  in/out/out/in  1 each: AXI-Lite read handshakes.
- `araddr`  in  pADDR_WIDTH; `rdata`  out  pDATA_WIDTH: read address and data.
- `ss_tvalid`  in  1; `ss_tdata`  in  pDATA_WIDTH; `ss_tlast`  in  1; `ss_tready`  out  1: input stream.
- `sm_tready`  in  1; `sm_tvalid`  out  1; `sm_tdata`  out  pDATA_WIDTH; `sm_tlast`  out  1: output stream.

## Operation
Register map:
- 0x00 ap_ctrl:
  - bit0 ap_start: write-1, self-clearing. Ignored unless idle.
  - bit1 ap_done: set on the last output handshake; cleared by a completed read of 0x00.
  - bit2 ap_idle.
  - bit4 tlast_err: sticky; cleared by ap_start.
- 0x10 dim N:
  - Reset value 4.
  - Writes accepted only while idle and only for 1 ≤ value ≤ MAX_N. Any other write is dropped and the old value is kept.
- Unmapped reads return 0. Unmapped writes are ignored.

Data:
- First N² input words are A, row-major. Next N² words are B, row-major.
- Output C[i][j] = Σₖ B[i][k]·A[k][j], emitted row-major, N² words.
- Each product is signed and truncated to pDATA_WIDTH. The accumulator wraps modulo 2^pDATA_WIDTH.
- One multiplier is used; one MAC per cycle.

FSM:
- IDLE: ap_idle=1, ss_tready=0. ap_start → LOAD; counters cleared.
- LOAD: ss_tready=1. Each handshake stores a word. After word 2N²−1 is accepted → MAC.
- MAC: exactly N cycles, k=0..N−1, then → OUT.
- OUT: sm_tvalid=1 until handshake.
  - sm_tlast=1 only on element N²−1.
  - Handshake on a non-final element → MAC for the next element.
  - Handshake on the final element → IDLE with ap_done=1.

tlast_err:
- Set if ss_tlast=1 on any accepted word other than index 2N²−1.
- Also set if ss_tlast=0 on that final word.
- Framing is count-based only; tlast never changes flow.

## Timing
- Reset values: awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast = 0; rdata, sm_tdata = 0; ap_idle=1, ap_done=0, tlast_err=0, N=4, state IDLE.
- Asserting reset mid-operation aborts immediately. Stored matrices are not cleared but are never reused.
- AXI-Lite write:
  - awready=wready=1 for exactly one cycle, the cycle after awvalid and wvalid are both high.
  - The register updates on that edge.
- AXI-Lite read:
  - arready pulses one cycle after arvalid.
  - rvalid rises the next cycle; rdata is held stable until rready.
  - Only one read is outstanding at a time.
- ap_start write → LOAD at the next edge; ss_tready=1 in the following cycle.
- ap_idle falls in the same cycle that LOAD is entered.
- Last input handshake → first sm_tvalid after N+1 cycles (N MAC cycles plus 1).
- Between outputs, each output handshake is followed by N MAC cycles, then sm_tvalid rises again.
- Backpressure: while sm_tvalid=1 and sm_tready=0, sm_tdata and sm_tlast hold stable.
- sm_tvalid falls the cycle after the handshake.
- Final output handshake → next cycle ap_done=1 and ap_idle=1.
- A read of 0x00 in the same cycle ap_done sets returns 1, and the bit then clears.
- ap_start during a non-idle state is dropped. A dim write during a non-idle state is dropped.

## Test plan
- Default N=4, A=1..16, B=2..17, ap_start=1 → 16 outputs; C[0][0]=118. sm_tlast only on the 16th output; afterwards 0x00 reads done=1, idle=1, and the next read shows done=0.
- Write dim=2, A=[1,2,3,4], B=[5,6,7,8] → outputs 23, 34, 31, 46. First sm_tvalid appears 3 cycles after the last input handshake.
- MAX_N=8, dim=8, all inputs 1 → 64 outputs, each 8. Write dim=9 → reads back 8. Write dim=0 → reads back 8.
- dim=1, A=0x40000000, B=4 → single output 0x00000000 (wrap), with sm_tlast=1.
- N=4 with sm_tready held low 5 cycles on output 3 → sm_tdata stable throughout and no output lost. ss_tlast on word 10 → tlast_err=1, all 16 outputs still correct, and the next ap_start clears the flag.
- Assert axis_rst_n low during MAC → all outputs return to reset values and ap_idle=1. A fresh N=4 run afterward passes.

Source files
------------

// File: rtl/mm_param.sv
// mm_param: run-time sized signed matrix multiply accelerator.
//
// Two N x N matrices (A, then B, each row-major) stream in on ss_*.
// The product C[i][j] = sum_k B[i][k] * A[k][j] streams out on sm_*,
// row-major. N is taken from the dim register. One multiply-accumulate
// is done per cycle. Products and the running sum wrap modulo
// 2^pDATA_WIDTH.
//
// Ports:
//   axis_clk, axis_rst_n        clock, asynchronous active-low reset
//   aw*/w*                      AXI-Lite write (0x00 ap_ctrl, 0x10 dim)
//   ar*/r*                      AXI-Lite read
//   ss_tvalid/tdata/tlast/tready  input stream (A then B)
//   sm_tvalid/tdata/tlast/tready  output stream (C)
//
// ap_ctrl read value: bit1 ap_done, bit2 ap_idle, bit4 tlast_err.
module mm_param #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int MAX_N       = 8
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    localparam int NW    = $clog2(MAX_N + 1);
    localparam int DEPTH = MAX_N * MAX_N;
    localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(2 * DEPTH + 1);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(0);
    localparam logic [pADDR_WIDTH-1:0] ADDR_DIM  = pADDR_WIDTH'(16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic                   aw_wready_q;
    logic                   arready_q;
    logic                   rvalid_q;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [NW-1:0]          dim_q;
    logic                   ap_done_q;
    logic                   tlast_err_q;
    logic [CW-1:0]          load_cnt_q;
    logic [NW-1:0]          row_q;
    logic [NW-1:0]          col_q;
    logic [NW-1:0]          k_q;
    logic [pDATA_WIDTH-1:0] acc_q;
    logic [pDATA_WIDTH-1:0] sm_tdata_q;
    logic                   sm_tlast_q;

    // A and B held separately so one MAC cycle can fetch one word of each.
    logic [pDATA_WIDTH-1:0] a_mem [DEPTH];
    logic [pDATA_WIDTH-1:0] b_mem [DEPTH];

    logic                   wr_fire;
    logic                   ar_fire;
    logic                   start_req;
    logic                   dim_wr_ok;
    logic                   rd_ctrl;
    logic                   in_fire;
    logic                   out_fire;
    logic                   done_set;
    logic [CW-1:0]          n_sq;
    logic                   last_in;
    logic                   in_is_a;
    logic                   k_last;
    logic                   col_last;
    logic                   row_last;
    logic                   elem_last;
    logic [MAW-1:0]         a_idx;
    logic [MAW-1:0]         b_idx;
    logic [pDATA_WIDTH-1:0] a_rd;
    logic [pDATA_WIDTH-1:0] b_rd;
    logic [pDATA_WIDTH-1:0] prod;
    logic [pDATA_WIDTH-1:0] mac_sum;
    logic [pDATA_WIDTH-1:0] rd_value;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign wr_fire   = aw_wready_q && awvalid && wvalid;
    assign ar_fire   = arready_q && arvalid;
    assign start_req = wr_fire && (awaddr == ADDR_CTRL) && wdata[0]
                       && (state_q == S_IDLE);
    assign dim_wr_ok = wr_fire && (awaddr == ADDR_DIM) && (state_q == S_IDLE)
                       && (wdata != '0) && (wdata <= pDATA_WIDTH'(MAX_N));
    assign rd_ctrl   = ar_fire && (araddr == ADDR_CTRL);

    assign in_fire   = (state_q == S_LOAD) && ss_tvalid;
    assign out_fire  = (state_q == S_OUT) && sm_tready;

    assign n_sq      = CW'(dim_q) * CW'(dim_q);
    assign last_in   = (load_cnt_q == (n_sq + n_sq - CW'(1)));
    assign in_is_a   = (load_cnt_q < n_sq);

    assign k_last    = (k_q == dim_q - NW'(1));
    assign col_last  = (col_q == dim_q - NW'(1));
    assign row_last  = (row_q == dim_q - NW'(1));
    assign elem_last = row_last && col_last;
    assign done_set  = out_fire && elem_last;

    // ------------------------------------------------------------------
    // MAC datapath: C[row][col] += B[row][k] * A[k][col]
    // ------------------------------------------------------------------
    assign a_idx = MAW'(k_q) * MAW'(dim_q) + MAW'(col_q);
    assign b_idx = MAW'(row_q) * MAW'(dim_q) + MAW'(k_q);
    assign a_rd  = a_mem[a_idx];
    assign b_rd  = b_mem[b_idx];

    // The low pDATA_WIDTH bits of a product are identical for signed and
    // unsigned operands, so the truncated signed product needs no sign care.
    assign prod    = a_rd * b_rd;
    assign mac_sum = ((k_q == '0) ? '0 : acc_q) + prod;

    always_ff @(posedge axis_clk) begin
        if (in_fire) begin
            if (in_is_a) begin
                a_mem[MAW'(load_cnt_q)] <= ss_tdata;
            end else begin
                b_mem[MAW'(load_cnt_q - n_sq)] <= ss_tdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read mux. ap_done is bypassed so a read landing on the
    // same edge the bit sets still observes it before it clears.
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = '0;
        if (araddr == ADDR_CTRL) begin
            rd_value[1] = ap_done_q | done_set;
            rd_value[2] = (state_q == S_IDLE);
            rd_value[4] = tlast_err_q;
        end else if (araddr == ADDR_DIM) begin
            rd_value = pDATA_WIDTH'(dim_q);
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and stream handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ss_tready = 1'b1;
                if (in_fire && last_in) begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (k_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                sm_tvalid = 1'b1;
                if (out_fire) begin
                    state_d = elem_last ? S_IDLE : S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= S_IDLE;
            aw_wready_q <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            dim_q       <= NW'(4);
            ap_done_q   <= 1'b0;
            tlast_err_q <= 1'b0;
            load_cnt_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // Write: single-cycle ready pulse once address and data are both up.
            aw_wready_q <= awvalid && wvalid && !aw_wready_q;

            // Read: no new address accepted while a response is pending.
            arready_q <= arvalid && !arready_q && !rvalid_q;
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_value;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end

            if (dim_wr_ok) begin
                dim_q <= wdata[NW-1:0];
            end

            if (rd_ctrl) begin
                ap_done_q <= 1'b0;
            end else if (done_set) begin
                ap_done_q <= 1'b1;
            end

            // Framing check only: a misplaced or missing tlast is flagged,
            // the word count alone decides where the frame ends.
            if (start_req) begin
                tlast_err_q <= 1'b0;
            end else if (in_fire && (ss_tlast != last_in)) begin
                tlast_err_q <= 1'b1;
            end

            if (start_req) begin
                load_cnt_q <= '0;
                row_q      <= '0;
                col_q      <= '0;
                k_q        <= '0;
            end

            if (in_fire) begin
                load_cnt_q <= load_cnt_q + CW'(1);
            end

            if (state_q == S_MAC) begin
                acc_q <= mac_sum;
                if (k_last) begin
                    k_q        <= '0;
                    sm_tdata_q <= mac_sum;
                    sm_tlast_q <= elem_last;
                end else begin
                    k_q <= k_q + NW'(1);
                end
            end

            if (out_fire && !elem_last) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + NW'(1);
                end else begin
                    col_q <= col_q + NW'(1);
                end
            end
        end
    end

    assign awready  = aw_wready_q;
    assign wready   = aw_wready_q;
    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign sm_tdata = sm_tdata_q;
    assign sm_tlast = sm_tlast_q && (state_q == S_OUT);

endmodule

// File: tb/tb_mm_param.sv
// Testbench for mm_param: directed scenarios, each task checking its own
// results against hand-computed constants or a small reference product.
module tb_mm_param;
    localparam logic [11:0] CTRL = 12'h000;
    localparam logic [11:0] DIM  = 12'h010;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [11:0] awaddr = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] wdata = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [11:0] araddr = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata = '0;
    logic        ss_tlast = 1'b0;
    logic        ss_tready;
    logic        sm_tready = 1'b1;
    logic        sm_tvalid;
    logic [31:0] sm_tdata;
    logic        sm_tlast;

    mm_param #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .MAX_N      (8)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .sm_tready (sm_tready),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_hs_cyc = 0;
    int first_valid_cyc = 0;
    int stall_bad = 0;
    int fall_bad = 0;

    logic [31:0] in_words [128];
    logic        in_last  [128];
    logic [31:0] out_data [64];
    logic        out_last [64];
    logic [31:0] exp_c    [64];

    // ---------------- drivers ----------------
    task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
        int guard;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        guard = 0;
        while (!(awready && wready) && guard < 20) begin
            @(posedge axis_clk); #1; guard++;
        end
        if (!(awready && wready)) begin
            checks++; errors++;
            $display("FAIL axil_write_timeout addr %0h got ready 0 want 1", addr);
        end else begin
            @(posedge axis_clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        $display("write addr=%0h data=%0h", addr, data);
    endtask

    task automatic axil_read(input logic [11:0] addr, output logic [31:0] data);
        int guard;
        data = '0;
        araddr = addr; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 20) begin
            @(posedge axis_clk); #1; guard++;
        end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL axil_read_ar_timeout addr %0h got arready 0 want 1", addr);
            arvalid = 1'b0;
            return;
        end
        @(posedge axis_clk); #1;
        arvalid = 1'b0;
        guard = 0;
        while (!rvalid && guard < 20) begin
            @(posedge axis_clk); #1; guard++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL axil_read_r_timeout addr %0h got rvalid 0 want 1", addr);
            return;
        end
        data = rdata;
        rready = 1'b1;
        @(posedge axis_clk); #1;
        rready = 1'b0;
        $display("read  addr=%0h data=%0h", addr, data);
    endtask

    task automatic send_words(input int nw);
        int guard;
        for (int w = 0; w < nw; w++) begin
            ss_tvalid = 1'b1; ss_tdata = in_words[w]; ss_tlast = in_last[w];
            guard = 0;
            while (!ss_tready && guard < 50) begin
                @(posedge axis_clk); #1; guard++;
            end
            if (!ss_tready) begin
                checks++; errors++;
                $display("FAIL ss_tready_timeout word %0d got 0 want 1", w);
                ss_tvalid = 1'b0; ss_tlast = 1'b0;
                return;
            end
            @(posedge axis_clk); #1;
        end
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
        last_hs_cyc = cyc;
        $display("sent %0d input words", nw);
    endtask

    task automatic collect(input int n, input int stall_idx, input int stall_len);
        int guard;
        stall_bad = 0; fall_bad = 0;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            while (!sm_tvalid && guard < 100) begin
                @(posedge axis_clk); #1; guard++;
            end
            if (!sm_tvalid) begin
                checks++; errors++;
                $display("FAIL sm_tvalid_timeout output %0d got 0 want 1", i);
                return;
            end
            if (i == 0) first_valid_cyc = cyc;
            out_data[i] = sm_tdata;
            out_last[i] = sm_tlast;
            if (i == stall_idx) begin
                sm_tready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge axis_clk); #1;
                    if (!sm_tvalid || sm_tdata !== out_data[i] || sm_tlast !== out_last[i])
                        stall_bad++;
                end
                sm_tready = 1'b1;
            end
            @(posedge axis_clk); #1;
            if (sm_tvalid !== 1'b0) fall_bad++;
            $display("output %0d data=%0h last=%0b", i, out_data[i], out_last[i]);
        end
    endtask

    // A = 1..n*n, B = 2..n*n+1, tlast only on the final word.
    task automatic fill_seq(input int n);
        for (int w = 0; w < 128; w++) begin
            in_words[w] = '0; in_last[w] = 1'b0;
        end
        for (int w = 0; w < 2 * n * n; w++) begin
            in_words[w] = (w < n * n) ? 32'(w + 1) : 32'(w - n * n + 2);
            in_last[w]  = (w == 2 * n * n - 1);
        end
    endtask

    // Reference: C[i][j] = sum_k B[i][k] * A[k][j], modulo 2^32.
    task automatic compute_expected(input int n);
        logic [31:0] acc;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = '0;
                for (int k = 0; k < n; k++)
                    acc = acc + in_words[n * n + i * n + k] * in_words[k * n + j];
                exp_c[i * n + j] = acc;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        axis_rst_n = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        checks++;
        if ({awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshakes got %b want 0000000",
                     {awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast});
        end
        checks++;
        if (rdata !== 32'h0 || sm_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got rdata %0h sm_tdata %0h want 0 0", rdata, sm_tdata);
        end
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL reset_ctrl got %0h want 4", rd);
        end
        axil_read(DIM, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL reset_dim got %0h want 4", rd);
        end
    endtask

    task automatic test_default_n4();
        logic [31:0] rd;
        fill_seq(4);
        compute_expected(4);
        axil_write(CTRL, 32'h1);
        send_words(32);
        collect(16, -1, 0);
        checks++;
        if (out_data[0] !== 32'd118) begin
            errors++; $display("FAIL n4_c00 got %0d want 118", out_data[0]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data[i] !== exp_c[i]) begin
                errors++; $display("FAIL n4_data[%0d] got %0h want %0h", i, out_data[i], exp_c[i]);
            end
            checks++;
            if (out_last[i] !== (i == 15)) begin
                errors++; $display("FAIL n4_tlast[%0d] got %0b want %0b", i, out_last[i], (i == 15));
            end
        end
        checks++;
        if (fall_bad !== 0) begin
            errors++; $display("FAIL n4_tvalid_fall got %0d late drops want 0", fall_bad);
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            errors++; $display("FAIL n4_done_read got %0h want 6", rd);
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL n4_done_clear got %0h want 4", rd);
        end
    endtask

    task automatic test_dim2();
        logic [31:0] rd;
        logic [31:0] want [4];
        want[0] = 32'd23; want[1] = 32'd34; want[2] = 32'd31; want[3] = 32'd46;
        axil_write(DIM, 32'd2);
        axil_read(DIM, rd);
        checks++;
        if (rd !== 32'd2) begin
            errors++; $display("FAIL dim2_readback got %0d want 2", rd);
        end
        fill_seq(2);
        for (int w = 0; w < 8; w++) in_words[w] = 32'(w + 1);
        axil_write(CTRL, 32'h1);
        send_words(8);
        collect(4, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_data[i] !== want[i] || out_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL dim2_out[%0d] got %0d/%0b want %0d/%0b",
                         i, out_data[i], out_last[i], want[i], (i == 3));
            end
        end
        checks++;
        if (first_valid_cyc - last_hs_cyc + 1 !== 3) begin
            errors++;
            $display("FAIL dim2_latency got %0d want 3", first_valid_cyc - last_hs_cyc + 1);
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            errors++; $display("FAIL dim2_ctrl got %0h want 6", rd);
        end
    endtask

    task automatic test_max();
        logic [31:0] rd;
        int bad_data;
        int bad_last;
        axil_write(DIM, 32'd8);
        for (int w = 0; w < 128; w++) begin
            in_words[w] = 32'd1; in_last[w] = 1'b0;
        end
        axil_write(CTRL, 32'h1);
        send_words(128);
        collect(64, -1, 0);
        bad_data = 0; bad_last = 0;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (out_data[i] !== 32'd8) begin
                errors++; bad_data++;
                $display("FAIL max_data[%0d] got %0d want 8", i, out_data[i]);
            end
            if (out_last[i] !== (i == 63)) bad_last++;
        end
        checks++;
        if (bad_last !== 0) begin
            errors++; $display("FAIL max_tlast got %0d misplaced want 0", bad_last);
        end
        // No tlast on the final word: error flag expected alongside done/idle.
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h16) begin
            errors++; $display("FAIL max_ctrl got %0h want 16", rd);
        end
        axil_write(DIM, 32'd9);
        axil_read(DIM, rd);
        checks++;
        if (rd !== 32'd8) begin
            errors++; $display("FAIL dim9_dropped got %0d want 8", rd);
        end
        axil_write(DIM, 32'd0);
        axil_read(DIM, rd);
        checks++;
        if (rd !== 32'd8) begin
            errors++; $display("FAIL dim0_dropped got %0d want 8", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        axil_write(DIM, 32'd1);
        fill_seq(1);
        in_words[0] = 32'h4000_0000;
        in_words[1] = 32'd4;
        axil_write(CTRL, 32'h1);
        send_words(2);
        collect(1, -1, 0);
        checks++;
        if (out_data[0] !== 32'h0 || out_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_out got %0h/%0b want 0/1", out_data[0], out_last[0]);
        end
        checks++;
        if (first_valid_cyc - last_hs_cyc + 1 !== 2) begin
            errors++;
            $display("FAIL wrap_latency got %0d want 2", first_valid_cyc - last_hs_cyc + 1);
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            errors++; $display("FAIL wrap_ctrl_err_cleared got %0h want 6", rd);
        end
    endtask

    task automatic test_backpressure_tlast();
        logic [31:0] rd;
        axil_write(DIM, 32'd4);
        fill_seq(4);
        in_last[10] = 1'b1;
        compute_expected(4);
        axil_write(CTRL, 32'h1);
        send_words(32);
        collect(16, 2, 5);
        checks++;
        if (stall_bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", stall_bad);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data[i] !== exp_c[i] || out_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL bp_out[%0d] got %0h/%0b want %0h/%0b",
                         i, out_data[i], out_last[i], exp_c[i], (i == 15));
            end
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h16) begin
            errors++; $display("FAIL bp_tlast_err got %0h want 16", rd);
        end
        // Fresh start clears the flag; the block is left in LOAD.
        axil_write(CTRL, 32'h1);
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL start_clears_err got %0h want 0", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        // Entered in LOAD: dim writes and repeated starts must be dropped.
        axil_write(DIM, 32'd2);
        axil_write(CTRL, 32'h1);
        axil_read(DIM, rd);
        checks++;
        if (rd !== 32'd4) begin
            errors++; $display("FAIL busy_dim_dropped got %0d want 4", rd);
        end
        fill_seq(4);
        send_words(32);
        repeat (2) @(posedge axis_clk);
        #1;
        checks++;
        if (sm_tvalid !== 1'b0) begin
            errors++; $display("FAIL mid_mac_valid got %0b want 0", sm_tvalid);
        end
        axis_rst_n = 1'b0;
        #1;
        checks++;
        if ({arready, rvalid, ss_tready, sm_tvalid, sm_tlast} !== 5'b0 || rdata !== 32'h0
            || sm_tdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b rdata %0h sm_tdata %0h want 0",
                     {arready, rvalid, ss_tready, sm_tvalid, sm_tlast}, rdata, sm_tdata);
        end
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++; $display("FAIL mid_reset_ctrl got %0h want 4", rd);
        end
        fill_seq(4);
        for (int w = 0; w < 32; w++) in_words[w] = 32'(3 * w) - 32'd20;
        compute_expected(4);
        axil_write(CTRL, 32'h1);
        send_words(32);
        collect(16, -1, 0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data[i] !== exp_c[i]) begin
                errors++;
                $display("FAIL post_reset_data[%0d] got %0h want %0h", i, out_data[i], exp_c[i]);
            end
        end
        axil_read(CTRL, rd);
        checks++;
        if (rd !== 32'h6) begin
            errors++; $display("FAIL post_reset_ctrl got %0h want 6", rd);
        end
    endtask

    initial begin
        test_reset();
        test_default_n4();
        test_dim2();
        test_max();
        test_wrap();
        test_backpressure_tlast();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
